mshr_alloc: RTL and testbench
=============================

Name: mshr_alloc

Overview:
- Miss-status holding register allocator for the data cache miss path.
- Tracks which MSHR entries are busy and the line address each one holds.
- Grants the lowest-indexed free entry to each new miss, merges secondary misses to an in-flight line, and frees entries when a refill completes.
- Sits between the cache miss detector (upstream) and the refill/memory request logic (downstream).

Parameters:
- LOG_ENTRIES, 2, log2 of the MSHR entry count; N = 2**LOG_ENTRIES entries.
- ADDR_W, 58, line-address width (byte address >> 6).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- alloc_valid  input  1  a miss requests an entry.
- alloc_addr  input  ADDR_W  line address of the miss.
- alloc_ready  output  1  the allocator accepts the request this cycle.
- resp_valid  output  1  one-cycle pulse, the cycle after an accept.
- resp_idx  output  LOG_ENTRIES  entry index granted or merged into.
- resp_merged  output  1  1 = secondary miss to an already-busy entry.
- free_valid  input  1  refill complete; release an entry.
- free_idx  input  LOG_ENTRIES  entry to release.
- busy_mask  output  N  current busy bit per entry (registered).
- occupancy  output  LOG_ENTRIES+1  count of busy entries, 0..N.
- free_err  output  1  sticky; set when a free targets a non-busy entry.

Behaviour:
- Reset (reset_n low, asynchronous): all entries free and stored addresses cleared; busy_mask=0, occupancy=0, resp_valid=0, resp_idx=0, resp_merged=0, free_err=0. Reset asserted mid-operation discards all entries and any pending response immediately.
- Address match (combinational): match[i] = busy[i] && addr[i]==alloc_addr. At most one entry can match.
- Free-slot selection (combinational): lowest index i with busy[i]==0. Full when busy_mask is all ones.
- alloc_ready:
  - match present: ready = 1 (merge).
  - no match, not full: ready = 1 (new allocation).
  - no match, full: ready = 0.
  - Ready depends only on the current registered state, never on a same-cycle free.
- Accept occurs when alloc_valid && alloc_ready at a clock edge.
  - Merge: no state change. Next cycle resp_valid=1, resp_idx=matching index, resp_merged=1.
  - New allocation: busy[sel] <= 1, addr[sel] <= alloc_addr. Next cycle resp_valid=1, resp_idx=sel, resp_merged=0.
- Latency is exactly one cycle from accept to response. The response has no backpressure. resp_valid is 0 in any cycle not following an accept. resp_idx and resp_merged hold their last values when resp_valid=0.
- Free: free_valid with busy[free_idx]=1 clears busy[free_idx] at the edge. free_valid with busy[free_idx]=0 changes no entry and sets free_err, which stays 1 until reset.
- Simultaneous free and allocate in the same cycle:
  - Both take effect at the same edge.
  - The allocation decision uses pre-edge state, so the entry being freed is not selectable this cycle.
  - A merge into an entry being freed in the same cycle is still reported as merged. The upstream requester treats the refill as already returned.
- occupancy: registered; updates by +1 on a new allocation, -1 on a valid free, net 0 when both happen. It always equals popcount(busy_mask).
- Stored addresses of freed entries are don't-care. They never cause a match because matching is gated by busy.

Optional Feature:
- Macro: MSHR_MERGE_EN.
- Defined: secondary-miss merging as described above.
- Not defined:
  - The match logic is removed.
  - A request whose address matches a busy entry sees alloc_ready=0 (stall) until that entry is freed.
  - resp_merged is tied to 0.
  - Non-matching requests behave unchanged.

Test Plan:
- Reset, then 4 back-to-back allocs to addrs 0x10,0x20,0x30,0x40 -> responses idx 0,1,2,3, merged=0; occupancy=4; busy_mask=4'b1111; 5th alloc to 0x50 sees alloc_ready=0.
- Full, free_idx=2 -> next cycle busy_mask=4'b1011. Alloc 0x50 -> idx 2. Then free idx 0 and 3, alloc 0x60 -> idx 0 (lowest free).
- Entries 0,1 busy, alloc to 0x20 with MSHR_MERGE_EN -> resp idx 1, merged=1, occupancy unchanged at 2. Without the macro -> alloc_ready=0 until free_idx=1, then allocation into idx 0 (if free) or the lowest free index.
- Full, same cycle free_idx=1 and alloc 0x70 -> alloc_ready=0 that cycle. Next cycle ready=1 and the grant is idx 1.
- free_idx=3 while entry 3 is free -> free_err=1 next cycle and stays 1; busy_mask and occupancy unchanged. Asserting reset_n=0 clears it asynchronously.
- Assert reset_n low mid-stream, one cycle after an accept -> resp_valid, busy_mask and occupancy drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mshr_alloc.sv
// MSHR allocator: grants the lowest free entry to each miss, frees entries on refill.
// Optional secondary-miss merging is enabled by defining MSHR_MERGE_EN.
module mshr_alloc #(
  parameter int LOG_ENTRIES = 2,
  parameter int ADDR_W      = 58
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         alloc_valid,
  input  logic [ADDR_W-1:0]            alloc_addr,
  output logic                         alloc_ready,
  output logic                         resp_valid,
  output logic [LOG_ENTRIES-1:0]       resp_idx,
  output logic                         resp_merged,
  input  logic                         free_valid,
  input  logic [LOG_ENTRIES-1:0]       free_idx,
  output logic [(1<<LOG_ENTRIES)-1:0]  busy_mask,
  output logic [LOG_ENTRIES:0]         occupancy,
  output logic                         free_err
);

  localparam int N = 1 << LOG_ENTRIES;

  logic [N-1:0]           busy;
  logic [ADDR_W-1:0]      line_addr [N];
  logic [N-1:0]           match;
  logic                   hit;
  logic                   full;
  logic [LOG_ENTRIES-1:0] sel_idx;
  logic [LOG_ENTRIES-1:0] grant_idx;
  logic                   accept;
  logic                   new_alloc;
  logic                   free_ok;
  logic [N-1:0]           alloc_set;
  logic [N-1:0]           free_clr;

  // Address compare is gated by busy so stale addresses of freed entries never hit.
  always_comb begin
    match   = '0;
    sel_idx = '0;
    for (int i = 0; i < N; i++) begin
      match[i] = busy[i] && (line_addr[i] == alloc_addr);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy[i]) sel_idx = LOG_ENTRIES'(i);
    end
  end

  assign hit  = |match;
  assign full = &busy;

`ifdef MSHR_MERGE_EN
  logic [LOG_ENTRIES-1:0] hit_idx;

  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (match[i]) hit_idx = LOG_ENTRIES'(i);
    end
  end

  assign alloc_ready = hit || !full;
  assign grant_idx   = hit ? hit_idx : sel_idx;
`else
  // Without merging, a miss to an in-flight line stalls until that entry is freed.
  assign alloc_ready = !hit && !full;
  assign grant_idx   = sel_idx;
`endif

  assign accept    = alloc_valid && alloc_ready;
  assign new_alloc = accept && !hit;
  assign free_ok   = free_valid && busy[free_idx];
  assign alloc_set = new_alloc ? (N'(1) << sel_idx) : '0;
  assign free_clr  = free_ok ? (N'(1) << free_idx) : '0;

  // A freed entry is busy before the edge, so it never collides with the selected slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= '0;
      occupancy <= '0;
      free_err  <= 1'b0;
      for (int i = 0; i < N; i++) line_addr[i] <= '0;
    end else begin
      busy <= (busy & ~free_clr) | alloc_set;
      if (new_alloc) line_addr[sel_idx] <= alloc_addr;
      if (new_alloc && !free_ok)
        occupancy <= occupancy + (LOG_ENTRIES+1)'(1);
      else if (free_ok && !new_alloc)
        occupancy <= occupancy - (LOG_ENTRIES+1)'(1);
      if (free_valid && !busy[free_idx]) free_err <= 1'b1;
    end
  end

  logic merged_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid <= 1'b0;
      resp_idx   <= '0;
      merged_q   <= 1'b0;
    end else begin
      resp_valid <= accept;
      if (accept) begin
        resp_idx <= grant_idx;
        merged_q <= hit;
      end
    end
  end

`ifdef MSHR_MERGE_EN
  assign resp_merged = merged_q;
`else
  assign resp_merged = 1'b0;
`endif

  assign busy_mask = busy;

endmodule

// File: tb/tb_mshr_alloc.sv
// Directed, table-driven bench for mshr_alloc; expectations adapt to MSHR_MERGE_EN.
module tb_mshr_alloc;

  logic        clk;
  logic        reset_n;
  logic        alloc_valid;
  logic [57:0] alloc_addr;
  logic        alloc_ready;
  logic        resp_valid;
  logic [1:0]  resp_idx;
  logic        resp_merged;
  logic        free_valid;
  logic [1:0]  free_idx;
  logic [3:0]  busy_mask;
  logic [2:0]  occupancy;
  logic        free_err;

  int passCount  = 0;
  int checkCount = 0;

`ifdef MSHR_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  typedef struct {
    logic        av;
    logic [57:0] addr;
    logic        fv;
    logic [1:0]  fidx;
    logic        eready;
    logic        evalid;
    logic [1:0]  eidx;
    logic        emerged;
    logic [3:0]  ebusy;
    logic [2:0]  eocc;
    logic        eerr;
  } vec_t;

  vec_t vecs[$];

  mshr_alloc #(.LOG_ENTRIES(2), .ADDR_W(58)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .alloc_ready (alloc_ready),
    .resp_valid  (resp_valid),
    .resp_idx    (resp_idx),
    .resp_merged (resp_merged),
    .free_valid  (free_valid),
    .free_idx    (free_idx),
    .busy_mask   (busy_mask),
    .occupancy   (occupancy),
    .free_err    (free_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic addVec(input logic av, input logic [57:0] addr, input logic fv,
                        input logic [1:0] fidx, input logic eready, input logic evalid,
                        input logic [1:0] eidx, input logic emerged, input logic [3:0] ebusy,
                        input logic [2:0] eocc, input logic eerr);
    vec_t v;
    v.av = av; v.addr = addr; v.fv = fv; v.fidx = fidx;
    v.eready = eready; v.evalid = evalid; v.eidx = eidx; v.emerged = emerged;
    v.ebusy = ebusy; v.eocc = eocc; v.eerr = eerr;
    vecs.push_back(v);
  endtask

  // Drive one vector after the falling edge, check ready mid-cycle and registered outputs after the rising edge.
  task automatic applyStimulus(input int n, input vec_t v);
    @(negedge clk);
    alloc_valid = v.av;
    alloc_addr  = v.addr;
    free_valid  = v.fv;
    free_idx    = v.fidx;
    #1;
    checkOutput($sformatf("v%0d alloc_ready", n), 64'(alloc_ready), 64'(v.eready));
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d resp_valid", n), 64'(resp_valid), 64'(v.evalid));
    if (v.evalid) begin
      checkOutput($sformatf("v%0d resp_idx", n), 64'(resp_idx), 64'(v.eidx));
      checkOutput($sformatf("v%0d resp_merged", n), 64'(resp_merged), 64'(v.emerged));
    end
    checkOutput($sformatf("v%0d busy_mask", n), 64'(busy_mask), 64'(v.ebusy));
    checkOutput($sformatf("v%0d occupancy", n), 64'(occupancy), 64'(v.eocc));
    checkOutput($sformatf("v%0d free_err", n), 64'(free_err), 64'(v.eerr));
  endtask

  initial begin
    reset_n     = 1'b0;
    alloc_valid = 1'b0;
    alloc_addr  = '0;
    free_valid  = 1'b0;
    free_idx    = '0;

    //      av  addr    fv  fidx rdy   rvalid  idx   merged  busy     occ  err
    addVec(1, 58'h10, 0, 0, 1, 1, 0, 0, 4'b0001, 1, 0);
    addVec(1, 58'h20, 0, 0, 1, 1, 1, 0, 4'b0011, 2, 0);
    addVec(1, 58'h20, 0, 0, MERGE, MERGE, 1, MERGE, 4'b0011, 2, 0);
    addVec(1, 58'h30, 0, 0, 1, 1, 2, 0, 4'b0111, 3, 0);
    addVec(1, 58'h40, 0, 0, 1, 1, 3, 0, 4'b1111, 4, 0);
    addVec(1, 58'h50, 0, 0, 0, 0, 0, 0, 4'b1111, 4, 0);
    addVec(1, 58'h70, 1, 1, 0, 0, 0, 0, 4'b1101, 3, 0);
    addVec(1, 58'h70, 0, 0, 1, 1, 1, 0, 4'b1111, 4, 0);
    addVec(0, 58'h0,  1, 2, 0, 0, 0, 0, 4'b1011, 3, 0);
    addVec(1, 58'h50, 0, 0, 1, 1, 2, 0, 4'b1111, 4, 0);
    addVec(0, 58'h0,  1, 0, 0, 0, 0, 0, 4'b1110, 3, 0);
    addVec(0, 58'h0,  1, 3, 1, 0, 0, 0, 4'b0110, 2, 0);
    addVec(1, 58'h60, 0, 0, 1, 1, 0, 0, 4'b0111, 3, 0);
    addVec(0, 58'h0,  1, 3, 1, 0, 0, 0, 4'b0111, 3, 1);
    addVec(1, 58'h40, 1, 1, 1, 1, 3, 0, 4'b1101, 3, 1);
    addVec(1, 58'h60, 1, 0, MERGE, MERGE, 0, MERGE, 4'b1100, 2, 1);
    addVec(0, 58'h0,  0, 0, 1, 0, 0, 0, 4'b1100, 2, 1);
    addVec(1, 58'h50, 0, 0, MERGE, MERGE, 2, MERGE, 4'b1100, 2, 1);
    addVec(1, 58'h50, 1, 2, MERGE, MERGE, 2, MERGE, 4'b1000, 1, 1);
    addVec(1, 58'h50, 0, 0, 1, 1, 0, 0, 4'b1001, 2, 1);

    #12;
    checkOutput("reset busy_mask", 64'(busy_mask), 64'h0);
    checkOutput("reset occupancy", 64'(occupancy), 64'h0);
    checkOutput("reset resp_valid", 64'(resp_valid), 64'h0);
    checkOutput("reset resp_idx", 64'(resp_idx), 64'h0);
    checkOutput("reset resp_merged", 64'(resp_merged), 64'h0);
    checkOutput("reset free_err", 64'(free_err), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(i, vecs[i]);

    // Asynchronous reset one cycle after an accept must clear state before any edge.
    @(negedge clk);
    alloc_valid = 1'b1;
    alloc_addr  = 58'h99;
    free_valid  = 1'b0;
    @(posedge clk);
    #1;
    alloc_valid = 1'b0;
    checkOutput("pre-reset resp_valid", 64'(resp_valid), 64'h1);
    checkOutput("pre-reset busy_mask", 64'(busy_mask), 64'b1011);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("async resp_valid", 64'(resp_valid), 64'h0);
    checkOutput("async busy_mask", 64'(busy_mask), 64'h0);
    checkOutput("async occupancy", 64'(occupancy), 64'h0);
    checkOutput("async free_err", 64'(free_err), 64'h0);
    checkOutput("async alloc_ready", 64'(alloc_ready), 64'h1);
    @(negedge clk);
    reset_n = 1'b1;

    // Addresses from before reset must not match once entries are cleared.
    @(negedge clk);
    alloc_valid = 1'b1;
    alloc_addr  = 58'h50;
    @(posedge clk);
    #1;
    alloc_valid = 1'b0;
    checkOutput("post-reset resp_idx", 64'(resp_idx), 64'h0);
    checkOutput("post-reset resp_merged", 64'(resp_merged), 64'h0);
    checkOutput("post-reset occupancy", 64'(occupancy), 64'h1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
